// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-master to one-slave Avalon-style bus arbiter
// with combinational passthrough in the granted state and a sticky stall watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] TMAX = W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [W-1:0]   wdog_q, wdog_d;
  logic [1:0]     grant_q;
  logic           err_q;
  logic           req0, req1, g0, g1, own_req, oth_req, stall, accept, done;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign g0      = state_q == GRANT0;
  assign g1      = state_q == GRANT1;
  assign own_req = g0 ? req0 : req1;
  assign oth_req = g0 ? req1 : req0;
  assign stall   = (g0 | g1) & own_req & s_waitrequest;
  assign accept  = (g0 | g1) & own_req & ~s_waitrequest;
  // done covers both acceptance and an abandoned (dropped) request
  assign done    = (g0 | g1) & ~stall;

  // read+write together is forwarded as a write
  assign s_address      = g0 ? m0_address : g1 ? m1_address : '0;
  assign s_write        = g0 ? m0_write : g1 ? m1_write : 1'b0;
  assign s_read         = g0 ? (m0_read & ~m0_write) : g1 ? (m1_read & ~m1_write) : 1'b0;
  assign s_writedata    = g0 ? m0_writedata : g1 ? m1_writedata : '0;
  assign s_byteenable   = g0 ? m0_byteenable : g1 ? m1_byteenable : '0;
  assign m0_waitrequest = g0 ? s_waitrequest : 1'b1;
  assign m1_waitrequest = g1 ? s_waitrequest : 1'b1;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign grant          = grant_q;
  assign timeout_err    = err_q;

  assign last_d  = done ? g1 : last_q;
  assign state_d = (state_q == IDLE) ?
                     ((req0 & req1) ? (last_q ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE) :
                   !done ? state_q :
                   oth_req ? (g0 ? GRANT1 : GRANT0) :
                   own_req ? state_q : IDLE;
  assign wdog_d  = (state_d != state_q || accept) ? '0 :
                   (stall && wdog_q != TMAX) ? wdog_q + 1'b1 : wdog_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      grant_q <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      grant_q <= {state_d == GRANT1, state_d == GRANT0};
      err_q   <= err_q | (wdog_d == TMAX);
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter; inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest = 1'b0;
  logic [31:0] s_readdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_grant", grant, 32'h0);
    chk("rst_err", timeout_err, 32'h0);
    chk("rst_m0_wait", m0_waitrequest, 32'h1);
    chk("rst_m1_wait", m1_waitrequest, 32'h1);
    chk("rst_s_read", s_read, 32'h0);
    @(negedge clk) reset = 1'b0;

    m0_read = 1'b1; m0_address = 32'h10; s_readdata = 32'hDEADBEEF;
    #1;
    chk("single_c1_wait", m0_waitrequest, 32'h1);
    chk("single_c1_grant", grant, 32'h0);
    chk("single_c1_sread", s_read, 32'h0);
    cyc();
    chk("single_c2_sread", s_read, 32'h1);
    chk("single_c2_addr", s_address, 32'h10);
    chk("single_c2_wait", m0_waitrequest, 32'h0);
    chk("single_c2_rdata", m0_readdata, 32'hDEADBEEF);
    chk("single_c2_grant", grant, 32'h1);
    chk("single_c2_m1wait", m1_waitrequest, 32'h1);
    m0_read = 1'b0;
    cyc();
    chk("single_idle_grant", grant, 32'h0);
    chk("single_idle_sread", s_read, 32'h0);

    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m0_write = 1'b1; m0_address = 32'h100; m0_writedata = 32'hAAAA0000;
    m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'hBBBB0000;
    #1;
    chk("cont_idle_swrite", s_write, 32'h0);
    chk("cont_idle_grant", grant, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cont_addr", s_address, (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("cont_wdata", s_writedata, (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB0000);
      chk("cont_grant", grant, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_m0_wait", m0_waitrequest, (i % 2 == 0) ? 32'h0 : 32'h1);
      chk("cont_m1_wait", m1_waitrequest, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    m0_write = 1'b0; m1_write = 1'b0;
    cyc();
    chk("cont_end_grant", grant, 32'h0);

    m1_write = 1'b1; m1_address = 32'h40; m1_writedata = 32'h12345678;
    m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
    cyc();
    m0_read = 1'b1; m0_address = 32'h80;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      else #1;
      chk("ws_addr", s_address, 32'h40);
      chk("ws_wdata", s_writedata, 32'h12345678);
      chk("ws_be", s_byteenable, 32'h3);
      chk("ws_swrite", s_write, 32'h1);
      chk("ws_m1_wait", m1_waitrequest, 32'h1);
      chk("ws_m0_wait", m0_waitrequest, 32'h1);
      chk("ws_grant", grant, 32'h2);
    end
    cyc();
    s_waitrequest = 1'b0;
    #1;
    chk("ws_acc_addr", s_address, 32'h40);
    chk("ws_acc_m1_wait", m1_waitrequest, 32'h0);
    chk("ws_acc_m0_wait", m0_waitrequest, 32'h1);
    cyc();
    m1_write = 1'b0;
    #1;
    chk("ws_m0_grant", grant, 32'h1);
    chk("ws_m0_sread", s_read, 32'h1);
    chk("ws_m0_addr", s_address, 32'h80);
    chk("ws_m0_wait0", m0_waitrequest, 32'h0);
    chk("ws_m0_m1wait", m1_waitrequest, 32'h1);
    m0_read = 1'b0;
    cyc();

    m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h20;
    cyc();
    chk("ill_swrite", s_write, 32'h1);
    chk("ill_sread", s_read, 32'h0);
    chk("ill_grant", grant, 32'h1);
    m0_read = 1'b0; m0_write = 1'b0;
    cyc();

    m0_read = 1'b1; m0_address = 32'h30; s_waitrequest = 1'b1;
    repeat (8) cyc();
    chk("wd_before", timeout_err, 32'h0);
    cyc();
    chk("wd_set", timeout_err, 32'h1);
    chk("wd_still_stalled", m0_waitrequest, 32'h1);
    s_waitrequest = 1'b0;
    cyc();
    m0_read = 1'b0;
    cyc();
    cyc();
    chk("wd_sticky", timeout_err, 32'h1);
    reset = 1'b1;
    #1;
    chk("wd_reset_err", timeout_err, 32'h0);
    @(negedge clk) reset = 1'b0;

    m1_write = 1'b1; m1_address = 32'h50; s_waitrequest = 1'b1;
    cyc();
    chk("ar_pre_grant", grant, 32'h2);
    chk("ar_pre_swrite", s_write, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("ar_swrite", s_write, 32'h0);
    chk("ar_grant", grant, 32'h0);
    chk("ar_m0_wait", m0_waitrequest, 32'h1);
    chk("ar_m1_wait", m1_waitrequest, 32'h1);
    @(negedge clk) reset = 1'b0;
    s_waitrequest = 1'b0;
    cyc();
    chk("ar_regrant", grant, 32'h2);
    chk("ar_reswrite", s_write, 32'h1);
    chk("ar_m1_wait0", m1_waitrequest, 32'h0);
    m1_write = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
